// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame FSM state encodings and default sizes.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StStart    = 3'd1;
    localparam state_t StStartChk = 3'd2;
    localparam state_t StData     = 3'd3;
    localparam state_t StParity   = 3'd4;
    localparam state_t StStop     = 3'd5;
    localparam state_t StDone     = 3'd6;
    localparam state_t StBreak    = 3'd7;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversample tick counter and data-bit counter for the RX frame sequencer.
// Produces the mid-start and full-bit sample strobes.
module uart_rx_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic UCLK,
    input  logic reset,
    input  logic baud_tick,
    input  logic cnt_clr,
    input  logic cnt_en,
    input  logic bit_clr,
    input  logic bit_adv,
    output logic mid_tick,
    output logic full_tick,
    output logic last_bit
);

    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] MidCnt  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_BITS - 1);

    logic [CNT_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    assign mid_tick  = baud_tick && (tick_q == MidCnt);
    assign full_tick = baud_tick && (tick_q == FullCnt);
    assign last_bit  = (bit_q == LastBit);

    // A clear that coincides with a counted tick lands at 1 so that tick is not lost.
    always_comb begin
        tick_d = tick_q;
        if (cnt_clr) begin
            tick_d = (cnt_en && baud_tick) ? CNT_W'(1) : '0;
        end else if (cnt_en && baud_tick) begin
            tick_d = (tick_q == FullCnt) ? '0 : tick_q + CNT_W'(1);
        end
    end

    always_comb begin
        bit_d = bit_q;
        if (bit_clr) begin
            bit_d = '0;
        end else if (bit_adv) begin
            bit_d = last_bit ? '0 : bit_q + BIT_W'(1);
        end
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
            bit_q  <= '0;
        end else begin
            tick_q <= tick_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start detect, start-bit check handshake, data/parity/stop capture.
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic                 UCLK,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 start_bit_error,
    output logic                 chk_en,
    output logic                 sampled_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);

    state_t state_q, state_d;

    logic                 mid_tick, full_tick, last_bit;
    logic                 cnt_clr, bit_clr;
    logic                 data_tick, par_tick, stop_tick, publish;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q, par_odd_q, par_err_q;
    logic                 sampled_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 parity_error_q, frame_error_q;

    uart_rx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .UCLK      (UCLK),
        .reset     (reset),
        .baud_tick (baud_tick),
        .cnt_clr   (cnt_clr),
        .cnt_en    (busy),
        .bit_clr   (bit_clr),
        .bit_adv   (data_tick),
        .mid_tick  (mid_tick),
        .full_tick (full_tick),
        .last_bit  (last_bit)
    );

    assign busy      = (state_q != StIdle);
    assign chk_en    = rx_en && (state_q == StStart) && mid_tick;
    assign data_tick = rx_en && (state_q == StData) && full_tick;
    assign par_tick  = rx_en && (state_q == StParity) && full_tick;
    assign stop_tick = rx_en && (state_q == StStop) && full_tick;

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q, par_bit_q, brk_frame;

    assign brk_frame = (shift_q == '0) && !(par_en_q && par_bit_q) && !rx_in;
    assign publish   = stop_tick && !brk_frame;
    assign rx_valid  = (state_q == StDone) && !brk_q;
    assign break_det = (state_q == StDone) && brk_q;

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            brk_q     <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (par_tick) par_bit_q <= rx_in;
            if (stop_tick) brk_q <= brk_frame;
        end
    end
`else
    assign publish  = stop_tick;
    assign rx_valid = (state_q == StDone);
`endif

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        bit_clr = 1'b0;
        if (!rx_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_in) begin
                        state_d = StStart;
                        cnt_clr = 1'b1;
                    end
                end
                StStart: if (mid_tick) state_d = StStartChk;
                // Checker result registered on entry to this state is valid now.
                StStartChk: begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                    state_d = start_bit_error ? StIdle : StData;
                end
                StData: begin
                    if (full_tick && last_bit) state_d = par_en_q ? StParity : StStop;
                end
                StParity: if (full_tick) state_d = StStop;
                StStop:   if (full_tick) state_d = StDone;
`ifdef UART_RX_BREAK_DETECT_EN
                StDone:  state_d = brk_q ? StBreak : StIdle;
                StBreak: if (rx_in) state_d = StIdle;
`else
                StDone:  state_d = StIdle;
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            par_err_q      <= 1'b0;
            sampled_q      <= 1'b0;
            rx_data_q      <= '0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            if (chk_en || data_tick || par_tick || stop_tick) sampled_q <= rx_in;
            // Frame format is latched once so register writes mid-frame are harmless.
            if (chk_en) begin
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
            end
            if (data_tick) shift_q <= {rx_in, shift_q[DATA_BITS-1:1]};
            if (par_tick) par_err_q <= ((^shift_q) ^ rx_in) != par_odd_q;
            if (publish) begin
                rx_data_q      <= shift_q;
                parity_error_q <= par_en_q && par_err_q;
                frame_error_q  <= ~rx_in;
            end
        end
    end

    assign sampled_bit  = sampled_q;
    assign rx_data      = rx_data_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;

endmodule
